// File: rtl/stop_watch_core.sv
// stop_watch_core: centisecond elapsed-time counter (hour:min:sec:csec).
// A prescaler divides clk down to TICK_HZ; each prescaler wrap advances a
// cascaded csec/sec/min/hour chain. tick, rollover and running are registered.
module stop_watch_core #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_stop,
  input  logic       clear,
  input  logic       mode,
  output logic [6:0] csec,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic       tick,
  output logic       rollover,
  output logic       running
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  generate
    if (DIV < 2) begin : g_div_check
      $error("stop_watch_core: CLK_FREQ / TICK_HZ must be at least 2");
    end
  endgenerate

  logic [PW-1:0] presc;
  logic          en;
  logic          step;
  logic          at_max;

  // Counting only in stopwatch mode; clear blocks the enable so a clear
  // edge can never also produce a step, tick or rollover.
  assign en     = mode & run_stop & ~clear;
  assign step   = en && (presc == PW'(DIV - 1));
  assign at_max = (csec == 7'd99) && (sec == 6'd59) && (min == 6'd59) && (hour == 5'd23);

  // Prescaler: holds while disabled so a resume finishes the partial period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (clear) begin
      presc <= '0;
    end else if (step) begin
      presc <= '0;
    end else if (en) begin
      presc <= presc + PW'(1);
    end
  end

  // Cascaded time fields; every carry is resolved on the same step edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csec <= '0;
      sec  <= '0;
      min  <= '0;
      hour <= '0;
    end else if (clear) begin
      csec <= '0;
      sec  <= '0;
      min  <= '0;
      hour <= '0;
    end else if (step) begin
      if (csec == 7'd99) begin
        csec <= '0;
        if (sec == 6'd59) begin
          sec <= '0;
          if (min == 6'd59) begin
            min <= '0;
            if (hour == 5'd23) begin
              hour <= '0;
            end else begin
              hour <= hour + 5'd1;
            end
          end else begin
            min <= min + 6'd1;
          end
        end else begin
          sec <= sec + 6'd1;
        end
      end else begin
        csec <= csec + 7'd1;
      end
    end
  end

  // Status pulses and the registered enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick     <= 1'b0;
      rollover <= 1'b0;
      running  <= 1'b0;
    end else begin
      tick     <= step;
      rollover <= step & at_max;
      running  <= en;
    end
  end

endmodule

// File: tb/tb_stop_watch_core.sv
// Bench for stop_watch_core with DIV = 10. Reference model tracks elapsed
// time as a single centisecond total plus a phase within the divide period.
module tb_stop_watch_core;

  localparam int DIV = 10;
  localparam int DAY = 8_640_000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run_stop = 1'b0;
  logic       clear = 1'b0;
  logic       mode = 1'b0;
  logic [6:0] csec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       tick;
  logic       rollover;
  logic       running;

  int n_tests = 0;
  int n_fail  = 0;

  stop_watch_core #(.CLK_FREQ(1000), .TICK_HZ(100)) dut (
    .clk(clk), .reset(reset), .run_stop(run_stop), .clear(clear), .mode(mode),
    .csec(csec), .sec(sec), .min(min), .hour(hour),
    .tick(tick), .rollover(rollover), .running(running)
  );

  always #5 clk = ~clk;

  // Reference model
  int   m_phase = 0;
  int   m_total = 0;
  logic m_tick = 1'b0;
  logic m_roll = 1'b0;
  logic m_run  = 1'b0;
  wire  en_in = mode & run_stop & ~clear;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 0; m_total <= 0; m_tick <= 1'b0; m_roll <= 1'b0; m_run <= 1'b0;
    end else begin
      m_run  <= en_in;
      m_tick <= 1'b0;
      m_roll <= 1'b0;
      if (clear) begin
        m_phase <= 0;
        m_total <= 0;
      end else if (en_in) begin
        if (m_phase == DIV - 1) begin
          m_phase <= 0;
          m_total <= (m_total + 1) % DAY;
          m_tick  <= 1'b1;
          m_roll  <= (m_total == DAY - 1);
        end else begin
          m_phase <= m_phase + 1;
        end
      end
    end
  end

  function automatic logic [26:0] exp_vec();
    int t;
    t = m_total;
    return {7'(t % 100), 6'((t / 100) % 60), 6'((t / 6000) % 60), 5'(t / 360000),
            m_tick, m_roll, m_run};
  endfunction

  wire [26:0] got_vec = {csec, sec, min, hour, tick, rollover, running};

  logic [6:0] pl_c;
  logic [5:0] pl_s;
  logic [5:0] pl_m;
  logic [4:0] pl_h;

  // Zero the prescaler with a one-cycle clear, then place the fields at a
  // chosen time (no input can load values, so the state is forced).
  task automatic preload(input int h, input int m, input int s, input int c);
    @(negedge clk);
    run_stop = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    pl_h = 5'(h); pl_m = 6'(m); pl_s = 6'(s); pl_c = 7'(c);
    force dut.hour = pl_h;
    force dut.min  = pl_m;
    force dut.sec  = pl_s;
    force dut.csec = pl_c;
    m_total = ((h * 60 + m) * 60 + s) * 100 + c;
    #1;
    release dut.hour;
    release dut.min;
    release dut.sec;
    release dut.csec;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (got_vec !== 27'd0) begin
      n_fail++; $display("FAIL reset_init: got %h expected %h", got_vec, 27'd0);
    end
    reset = 1'b0;
    preload(3, 0, 0, 57);
    mode = 1'b1; run_stop = 1'b1;
    repeat ($urandom_range(3, 25)) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_tests++;
    if (got_vec !== 27'd0) begin
      n_fail++; $display("FAIL reset_async: got %h expected %h", got_vec, 27'd0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (got_vec !== 27'd0) begin
        n_fail++; $display("FAIL reset_hold cyc %0d: got %h expected %h", i, got_vec, 27'd0);
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      n_tests++;
      if (got_vec !== exp_vec()) begin
        n_fail++; $display("FAIL reset_resume cyc %0d: got %h expected %h", i, got_vec, exp_vec());
      end
    end
  endtask

  task automatic test_count();
    int last_tick;
    preload(0, 0, 0, 0);
    mode = 1'b1; run_stop = 1'b1;
    last_tick = -1;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      n_tests++;
      if (got_vec !== exp_vec()) begin
        n_fail++; $display("FAIL count cyc %0d: got %h expected %h", i, got_vec, exp_vec());
      end
      if (i == 10) begin
        n_tests++;
        if (csec !== 7'd1 || tick !== 1'b1) begin
          n_fail++; $display("FAIL count_first: got csec=%0d tick=%b expected csec=1 tick=1", csec, tick);
        end
      end
      if (tick === 1'b1) begin
        if (last_tick >= 0) begin
          n_tests++;
          if (i - last_tick != DIV) begin
            n_fail++; $display("FAIL tick_period: got %0d expected %0d", i - last_tick, DIV);
          end
        end
        last_tick = i;
      end
    end
    n_tests++;
    if (csec !== 7'd0 || sec !== 6'd1) begin
      n_fail++; $display("FAIL count_1000: got sec=%0d csec=%0d expected sec=1 csec=0", sec, csec);
    end
  endtask

  task automatic test_pause();
    preload(0, 0, 0, 0);
    mode = 1'b1; run_stop = 1'b1;
    repeat (4) @(negedge clk);
    run_stop = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      n_tests++;
      if (got_vec !== exp_vec() || tick !== 1'b0 || csec !== 7'd0) begin
        n_fail++; $display("FAIL pause cyc %0d: got %h expected %h", i, got_vec, exp_vec());
      end
    end
    run_stop = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_tests++;
      if (got_vec !== exp_vec()) begin
        n_fail++; $display("FAIL resume cyc %0d: got %h expected %h", i, got_vec, exp_vec());
      end
      if (i == 5 || i == 6) begin
        n_tests++;
        if (csec !== 7'(i - 5)) begin
          n_fail++; $display("FAIL resume_latency cyc %0d: got csec=%0d expected %0d", i, csec, i - 5);
        end
      end
    end
  endtask

  task automatic test_mode();
    logic [26:0] held;
    preload(0, $urandom_range(0, 59), $urandom_range(0, 59), $urandom_range(0, 99));
    mode = 1'b0; run_stop = 1'b1;
    @(negedge clk);
    held = got_vec;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      n_tests++;
      if (got_vec !== exp_vec() || running !== 1'b0) begin
        n_fail++; $display("FAIL mode0 cyc %0d: got %h expected %h", i, got_vec, exp_vec());
      end
    end
    n_tests++;
    if (got_vec !== held) begin
      n_fail++; $display("FAIL mode0_hold: got %h expected %h", got_vec, held);
    end
    mode = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      n_tests++;
      if (got_vec !== exp_vec()) begin
        n_fail++; $display("FAIL mode1 cyc %0d: got %h expected %h", i, got_vec, exp_vec());
      end
    end
  endtask

  task automatic test_rollover();
    preload(23, 59, 59, 98);
    mode = 1'b1; run_stop = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      n_tests++;
      if (got_vec !== exp_vec()) begin
        n_fail++; $display("FAIL rollover cyc %0d: got %h expected %h", i, got_vec, exp_vec());
      end
      if (i == 20 || i == 21) begin
        n_tests++;
        if (rollover !== (i == 20) || hour !== 5'd0 || csec !== 7'd0) begin
          n_fail++; $display("FAIL rollover_pulse cyc %0d: got roll=%b hour=%0d csec=%0d expected roll=%b hour=0 csec=0",
                             i, rollover, hour, csec, i == 20);
        end
      end
    end
    preload(0, 0, 59, 99);
    mode = 1'b1; run_stop = 1'b1;
    repeat (10) @(negedge clk);
    n_tests++;
    if (got_vec !== exp_vec() || min !== 6'd1 || sec !== 6'd0) begin
      n_fail++; $display("FAIL sec_carry: got %h expected %h", got_vec, exp_vec());
    end
    preload(0, 59, 59, 99);
    mode = 1'b1; run_stop = 1'b1;
    repeat (10) @(negedge clk);
    n_tests++;
    if (got_vec !== exp_vec() || hour !== 5'd1 || min !== 6'd0 || rollover !== 1'b0) begin
      n_fail++; $display("FAIL min_carry: got %h expected %h", got_vec, exp_vec());
    end
  endtask

  task automatic test_clear_collide();
    preload(0, 0, 12, $urandom_range(0, 98));
    mode = 1'b1; run_stop = 1'b1;
    repeat (9) @(negedge clk);
    clear = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (got_vec !== 27'd0 || got_vec !== exp_vec()) begin
        n_fail++; $display("FAIL clear_hold cyc %0d: got %h expected %h", i, got_vec, 27'd0);
      end
    end
    clear = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_tests++;
      if (got_vec !== exp_vec()) begin
        n_fail++; $display("FAIL clear_release cyc %0d: got %h expected %h", i, got_vec, exp_vec());
      end
      if (i == 9 || i == 10) begin
        n_tests++;
        if (csec !== 7'(i - 9)) begin
          n_fail++; $display("FAIL clear_latency cyc %0d: got csec=%0d expected %0d", i, csec, i - 9);
        end
      end
    end
  endtask

  task automatic test_random();
    preload(23, 59, 58, 50);
    mode = 1'b1; run_stop = 1'b1;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      n_tests++;
      if (got_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc %0d: got %h expected %h", i, got_vec, exp_vec());
      end
      run_stop = ($urandom_range(0, 9) != 0);
      mode     = ($urandom_range(0, 19) != 0);
      clear    = ($urandom_range(0, 199) == 0);
    end
    clear = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_count();
    test_pause();
    test_mode();
    test_rollover();
    test_clear_collide();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
